vc_pop_scheduler: RTL and testbench
===================================

Name: vc_pop_scheduler

Overview:
- Parametrised successor of the two-channel empty/pause pop controller. Drains NUM_VC virtual-channel FIFOs toward the crossbar.
- Issues pop strobes, which are combinational to the FIFOs, and registered valid strobes, which are one cycle later and aligned with FIFO read data.
- Global pause from NUM_DEST destinations, followed by a programmable resume hold-off.
- Mode is either parallel (all non-empty channels pop) or round-robin (one pop per cycle).
- Per-channel saturating pop counters for debug.

Parameters:
- NUM_VC, 2, number of virtual channels (≥1)
- NUM_DEST, 2, number of destination pause inputs (≥1)
- MODE, 0, 0 = parallel pop, 1 = round-robin single pop
- RESUME_DLY, 2, cycles held in RESUME after pause falls before pops restart (0 = immediate)
- CNT_W, 16, width of each pop counter

Ports:
- clk  in  1  clock, rising edge
- reset_L  in  1  asynchronous active-low reset
- vc_empty  in  NUM_VC  FIFO empty flags, bit i = channel i
- pause_d  in  NUM_DEST  destination pause requests
- enable  in  1  global pop enable; 0 blocks pops without changing state
- clr_counts  in  1  synchronous clear of all pop counters
- pop_vc  out  NUM_VC  combinational pop strobes to FIFOs
- valid_vc  out  NUM_VC  registered; valid_vc[i] = pop_vc[i] delayed one cycle
- paused  out  1  high whenever state ≠ RUN
- pop_count  out  NUM_VC*CNT_W  flattened counters; channel i occupies bits [i*CNT_W +: CNT_W]

Behaviour:
- Reset (reset_L low, asynchronous):
  - state = RUN, rr_ptr = 0, hold-off counter = 0.
  - valid_vc = 0, all pop_count = 0.
  - pop_vc forced 0 while reset_L is low.
- pause_any = OR of pause_d.
- allow = enable & (state == RUN) & !pause_any. pause_any blocks pops in the same cycle it rises, with no extra latency.
- FSM, states RUN / PAUSED / RESUME, transitions on posedge:
  - RUN: pause_any → PAUSED.
  - PAUSED: stays while pause_any. On !pause_any → RESUME and loads the counter with RESUME_DLY-1. If RESUME_DLY == 0, goes directly to RUN.
  - RESUME: pause_any → PAUSED (pause has priority). Otherwise, counter == 0 → RUN, else decrement.
  - Pops are blocked in PAUSED and RESUME. The first pop after pause falls therefore occurs exactly RESUME_DLY+1 cycles after the first cycle with pause_any low.
- MODE 0: pop_vc[i] = allow & !vc_empty[i].
- MODE 1:
  - grant = first non-empty channel searching from rr_ptr upward, wrapping modulo NUM_VC.
  - pop_vc = one-hot(grant) when allow and at least one channel is non-empty, else 0.
  - On a pop, rr_ptr <= grant+1, wrapping to 0 after NUM_VC-1. Otherwise rr_ptr is unchanged.
  - NUM_VC == 1 behaves identically to MODE 0.
- valid_vc <= pop_vc every cycle. Latency is exactly 1 cycle, with no bubble insertion.
- A channel whose vc_empty is high is never popped, in any state.
- pop_count[i]:
  - Increments on pop_vc[i] and saturates at all-ones (no wrap).
  - clr_counts has priority over increment in the same cycle, giving 0 on the next cycle.
- enable low: pops = 0, FSM and hold-off counter continue to run, rr_ptr frozen.
- Reset asserted mid-operation: all registers clear immediately. The counter restarts from RUN after release, so a pending hold-off is discarded.

Decomposition:
- Shared package vc_pkg:
  - MODE_PARALLEL = 0, MODE_RR = 1.
  - 2-bit state encoding: RUN = 0, PAUSED = 1, RESUME = 2.
- One sub-module, vc_rr_arbiter:
  - Parametrised by NUM_VC.
  - Inputs: req, ptr, en. Outputs: one-hot gnt, gnt_idx, any.
  - Purely combinational.
  - Instantiated only when MODE == 1 (generate).

Test Plan:
1. MODE 0, NUM_VC 2, no pause, vc_empty = 2'b10 → pop_vc = 2'b01 in the same cycle; valid_vc = 2'b01 one cycle later; pop_count[0] = 1.
2. MODE 0, pause_d[1] rises while both channels are non-empty → pop_vc = 0 in that cycle and paused = 1 next cycle. With RESUME_DLY = 2 and pause released at cycle T, the first pop is at T+3.
3. MODE 1, NUM_VC 4, all non-empty for 8 cycles → grants 0,1,2,3,0,1,2,3. With vc_empty = 4'b0101, grants alternate 1, 3.
4. Pause re-asserted during RESUME (RESUME_DLY = 3, re-pause at release+1) → FSM returns to PAUSED; no pop occurs until a full new hold-off completes.
5. CNT_W = 3, channel 0 popped 10 times → pop_count[0] sticks at 7. clr_counts asserted in the same cycle as a pop → count reads 0.
6. Async reset asserted mid-RESUME with pops pending → pop_vc, valid_vc and counts go to 0 immediately, not waiting for clk. After release, pops resume in the first cycle with RUN state.

Source files
------------

// File: rtl/vc_pkg.sv
// Shared definitions for the virtual-channel pop scheduler: mode selectors,
// FSM state encoding and a pointer-width helper.
package vc_pkg;

    localparam int MODE_PARALLEL = 0;
    localparam int MODE_RR       = 1;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_RESUME = 2'd2
    } state_e;

    // Width of an index into n channels; a single channel still gets one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vc_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or above
// ptr, wrapping modulo NUM_VC. gnt is suppressed when en is low, but gnt_idx
// and any still report what would have been granted.
module vc_rr_arbiter
    import vc_pkg::*;
#(
    parameter int NUM_VC = 2,
    localparam int PTR_W = ptr_width(NUM_VC)
) (
    input  logic [NUM_VC-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    input  logic              en,
    output logic [NUM_VC-1:0] gnt,
    output logic [PTR_W-1:0]  gnt_idx,
    output logic              any
);

    int   idx;
    logic found;

    // Scan upward from ptr and latch onto the first requesting channel.
    always_comb begin
        // NOTE: every output gets a default before the loop, so no path leaves a
        // variable unassigned and no latch is inferred; blocking '=' is correct
        // here because later statements must see the earlier updates.
        gnt     = '0;
        gnt_idx = ptr;
        found   = 1'b0;
        idx     = 0;
        any     = |req;
        for (int k = 0; k < NUM_VC; k++) begin
            idx = (int'(ptr) + k) % NUM_VC;
            if (!found && req[idx]) begin
                found   = 1'b1;
                gnt_idx = PTR_W'(idx);
            end
        end
        if (en && any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/vc_pop_scheduler.sv
// Drains NUM_VC virtual-channel FIFOs: combinational pop strobes, registered
// valid strobes aligned with FIFO read data, global pause with a resume
// hold-off, parallel or round-robin pop policy, saturating debug counters.
module vc_pop_scheduler
    import vc_pkg::*;
#(
    parameter int NUM_VC     = 2,
    parameter int NUM_DEST   = 2,
    parameter int MODE       = MODE_PARALLEL,
    parameter int RESUME_DLY = 2,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic [NUM_VC-1:0]       vc_empty,
    input  logic [NUM_DEST-1:0]     pause_d,
    input  logic                    enable,
    input  logic                    clr_counts,
    output logic [NUM_VC-1:0]       pop_vc,
    output logic [NUM_VC-1:0]       valid_vc,
    output logic                    paused,
    output logic [NUM_VC*CNT_W-1:0] pop_count
);

    localparam int PTR_W = ptr_width(NUM_VC);
    localparam int DLY_W = (RESUME_DLY > 1) ? $clog2(RESUME_DLY) : 1;
    localparam logic [DLY_W-1:0] DLY_LOAD =
        (RESUME_DLY > 0) ? DLY_W'(RESUME_DLY - 1) : '0;

    state_e              state_q;
    logic [DLY_W-1:0]    hold_q;
    logic                pause_any;
    logic                allow;
    logic [NUM_VC-1:0]   pop;
    logic [NUM_VC-1:0]   valid_q;
    logic [CNT_W-1:0]    cnt_q [NUM_VC];
    logic [CNT_W-1:0]    cnt_d [NUM_VC];

    // Pause blocks pops in the cycle it rises; reset_L gates pops off directly
    // because the state already reads RUN while reset is held.
    assign pause_any = |pause_d;
    assign allow     = reset_L & enable & (state_q == ST_RUN) & ~pause_any;
    assign paused    = (state_q != ST_RUN);
    assign pop_vc    = pop;
    assign valid_vc  = valid_q;

    // Pause / resume hold-off FSM; runs regardless of enable.
    always_ff @(posedge clk or negedge reset_L) begin
        // NOTE: sequential state uses non-blocking '<=' so every flop samples
        // pre-edge values and simulation matches the synthesized registers.
        if (!reset_L) begin
            state_q <= ST_RUN;
            hold_q  <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (pause_any) state_q <= ST_PAUSED;
                end
                ST_PAUSED: begin
                    if (!pause_any) begin
                        if (RESUME_DLY == 0) begin
                            state_q <= ST_RUN;
                        end else begin
                            state_q <= ST_RESUME;
                            hold_q  <= DLY_LOAD;
                        end
                    end
                end
                ST_RESUME: begin
                    if (pause_any)         state_q <= ST_PAUSED;
                    else if (hold_q == '0) state_q <= ST_RUN;
                    else                   hold_q  <= hold_q - 1'b1;
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    if (MODE == MODE_RR && NUM_VC > 1) begin : g_rr
        logic [PTR_W-1:0]  rr_ptr_q;
        logic [PTR_W-1:0]  rr_ptr_d;
        logic [NUM_VC-1:0] gnt;
        logic [PTR_W-1:0]  gnt_idx;
        logic              any;

        vc_rr_arbiter #(.NUM_VC(NUM_VC)) u_arb (
            .req     (~vc_empty),
            .ptr     (rr_ptr_q),
            .en      (allow),
            .gnt     (gnt),
            .gnt_idx (gnt_idx),
            .any     (any)
        );

        assign pop = gnt;

        // Advance the pointer past the granted channel only when a pop happens.
        always_comb begin
            rr_ptr_d = rr_ptr_q;
            if (allow && any) begin
                rr_ptr_d = (gnt_idx == PTR_W'(NUM_VC - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end

        // Round-robin pointer register.
        always_ff @(posedge clk or negedge reset_L) begin
            if (!reset_L) rr_ptr_q <= '0;
            else          rr_ptr_q <= rr_ptr_d;
        end
    end else begin : g_par
        assign pop = {NUM_VC{allow}} & ~vc_empty;
    end

    // Saturating per-channel counters; clear wins over increment.
    always_comb begin
        for (int i = 0; i < NUM_VC; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clr_counts) begin
                cnt_d[i] = '0;
            end else if (pop[i] && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Valid strobes and counter registers.
    always_ff @(posedge clk or negedge reset_L) begin
        // NOTE: the counter array is ordinary flops read by software, so it is
        // reset explicitly rather than left as uninitialized storage.
        if (!reset_L) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_VC; i++) cnt_q[i] <= '0;
        end else begin
            valid_q <= pop;
            for (int i = 0; i < NUM_VC; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    for (genvar i = 0; i < NUM_VC; i++) begin : g_flat
        assign pop_count[i*CNT_W +: CNT_W] = cnt_q[i];
    end

endmodule

// File: tb/tb_vc_pop_scheduler.sv
// Scoreboard bench: drivers push the expected per-cycle response when they
// apply stimulus; a negedge monitor pops and compares against each DUT.
module tb_vc_pop_scheduler;

    typedef struct {
        string       tag;
        logic [3:0]  pop;
        logic [3:0]  valid;
        logic        paused;
        int          ch;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    // DUT 0: parallel, 2 channels, RESUME_DLY 2, 3-bit counters
    logic       rst0_n, en0, clr0;
    logic [1:0] emp0, pau0, pop0, val0;
    logic       pd0;
    logic [5:0] cnt0;

    vc_pop_scheduler #(.NUM_VC(2), .NUM_DEST(2), .MODE(0), .RESUME_DLY(2), .CNT_W(3)) u0 (
        .clk(clk), .reset_L(rst0_n), .vc_empty(emp0), .pause_d(pau0), .enable(en0),
        .clr_counts(clr0), .pop_vc(pop0), .valid_vc(val0), .paused(pd0), .pop_count(cnt0)
    );

    // DUT 1: round-robin, 4 channels, RESUME_DLY 3, 16-bit counters
    logic        rst1_n, en1, clr1;
    logic [3:0]  emp1, pop1, val1;
    logic [1:0]  pau1;
    logic        pd1;
    logic [63:0] cnt1;

    vc_pop_scheduler #(.NUM_VC(4), .NUM_DEST(2), .MODE(1), .RESUME_DLY(3), .CNT_W(16)) u1 (
        .clk(clk), .reset_L(rst1_n), .vc_empty(emp1), .pause_d(pau1), .enable(en1),
        .clr_counts(clr1), .pop_vc(pop1), .valid_vc(val1), .paused(pd1), .pop_count(cnt1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare each DUT against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (q0.size() > 0) begin
            e0 = q0.pop_front();
            check({e0.tag, " pop"},    {2'b00, pop0}, e0.pop);
            check({e0.tag, " valid"},  {2'b00, val0}, e0.valid);
            check({e0.tag, " paused"}, pd0, e0.paused);
            if (e0.ch >= 0) check({e0.tag, " cnt"}, cnt0[e0.ch*3 +: 3], e0.cnt);
        end
        if (q1.size() > 0) begin
            e1 = q1.pop_front();
            check({e1.tag, " pop"},    pop1, e1.pop);
            check({e1.tag, " valid"},  val1, e1.valid);
            check({e1.tag, " paused"}, pd1, e1.paused);
            if (e1.ch >= 0) check({e1.tag, " cnt"}, cnt1[e1.ch*16 +: 16], e1.cnt);
        end
    end

    task automatic s0(input string tag, input logic [1:0] emp, input logic [1:0] pau,
                      input logic en, input logic clr, input logic [1:0] ep,
                      input logic [1:0] ev, input logic epd, input int ch, input logic [15:0] ec);
        @(posedge clk);
        #1;
        emp0 = emp; pau0 = pau; en0 = en; clr0 = clr;
        q0.push_back('{tag, {2'b00, ep}, {2'b00, ev}, epd, ch, ec});
    endtask

    task automatic s1(input string tag, input logic [3:0] emp, input logic [1:0] pau,
                      input logic [3:0] ep, input logic [3:0] ev, input logic epd,
                      input int ch, input logic [15:0] ec);
        @(posedge clk);
        #1;
        rst1_n = 1'b1; emp1 = emp; pau1 = pau;
        q1.push_back('{tag, ep, ev, epd, ch, ec});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] pa, pv;
        rst0_n = 1'b0; emp0 = 2'b00; pau0 = 2'b00; en0 = 1'b1; clr0 = 1'b0;
        rst1_n = 1'b0; emp1 = 4'b0000; pau1 = 2'b00; en1 = 1'b1; clr1 = 1'b0;
        #3;
        // Reset state, with non-empty channels present
        check("rst u0 pop", pop0, 2'b00);
        check("rst u0 valid", val0, 2'b00);
        check("rst u0 paused", pd0, 1'b0);
        check("rst u0 counts", cnt0, 6'd0);
        check("rst u1 pop", pop1, 4'b0000);
        check("rst u1 valid", val1, 4'b0000);
        check("rst u1 counts", cnt1, 64'd0);
        emp0 = 2'b11; emp1 = 4'b1111;
        #1 rst0_n = 1'b1;

        // ---- DUT 0: parallel mode ----
        s0("u0 c1 single",   2'b10, 2'b00, 1, 0, 2'b01, 2'b00, 0, 0, 0);
        s0("u0 c2 latency",  2'b11, 2'b00, 1, 0, 2'b00, 2'b01, 0, 0, 1);
        s0("u0 c3 both",     2'b00, 2'b00, 1, 0, 2'b11, 2'b00, 0, 0, 1);
        s0("u0 c4 pauserise",2'b00, 2'b10, 1, 0, 2'b00, 2'b11, 0, 0, 2);
        s0("u0 c5 paused",   2'b00, 2'b10, 1, 0, 2'b00, 2'b00, 1, -1, 0);
        s0("u0 c6 release",  2'b00, 2'b00, 1, 0, 2'b00, 2'b00, 1, -1, 0);
        s0("u0 c7 hold1",    2'b00, 2'b00, 1, 0, 2'b00, 2'b00, 1, -1, 0);
        s0("u0 c8 hold2",    2'b00, 2'b00, 1, 0, 2'b00, 2'b00, 1, -1, 0);
        s0("u0 c9 firstpop", 2'b00, 2'b00, 1, 0, 2'b11, 2'b00, 0, 0, 2);
        s0("u0 c10 disable", 2'b00, 2'b00, 0, 0, 2'b00, 2'b11, 0, 0, 3);
        s0("u0 c11 reenable",2'b10, 2'b00, 1, 0, 2'b01, 2'b00, 0, 0, 3);
        for (int k = 0; k < 5; k++) begin
            s0($sformatf("u0 sat%0d", k), 2'b10, 2'b00, 1, 0, 2'b01, 2'b01, 0, 0,
               (k + 4 > 7) ? 16'd7 : 16'(k + 4));
        end
        s0("u0 c17 clrpop",  2'b10, 2'b00, 1, 1, 2'b01, 2'b01, 0, 0, 7);
        s0("u0 c18 cleared", 2'b11, 2'b00, 1, 0, 2'b00, 2'b01, 0, 0, 0);
        s0("u0 c19 ch1",     2'b11, 2'b00, 1, 0, 2'b00, 2'b00, 0, 1, 0);

        // ---- DUT 1: round-robin ----
        @(negedge clk);
        #1;
        for (int k = 0; k < 8; k++) begin
            pa = 4'b0001 << (k % 4);
            pv = (k == 0) ? 4'b0000 : 4'b0001 << ((k - 1) % 4);
            s1($sformatf("u1 rr%0d", k), 4'b0000, 2'b00, pa, pv, 0, -1, 0);
        end
        s1("u1 alt0", 4'b0101, 2'b00, 4'b0010, 4'b1000, 0, -1, 0);
        s1("u1 alt1", 4'b0101, 2'b00, 4'b1000, 4'b0010, 0, -1, 0);
        s1("u1 alt2", 4'b0101, 2'b00, 4'b0010, 4'b1000, 0, -1, 0);
        s1("u1 alt3", 4'b0101, 2'b00, 4'b1000, 4'b0010, 0, -1, 0);
        // Re-pause during RESUME
        s1("u1 b1 pause",    4'b0000, 2'b01, 4'b0000, 4'b1000, 0, -1, 0);
        s1("u1 b2 paused",   4'b0000, 2'b01, 4'b0000, 4'b0000, 1, -1, 0);
        s1("u1 b3 release",  4'b0000, 2'b00, 4'b0000, 4'b0000, 1, -1, 0);
        s1("u1 b4 repause",  4'b0000, 2'b01, 4'b0000, 4'b0000, 1, -1, 0);
        s1("u1 b5 release2", 4'b0000, 2'b00, 4'b0000, 4'b0000, 1, -1, 0);
        s1("u1 b6 hold",     4'b0000, 2'b00, 4'b0000, 4'b0000, 1, -1, 0);
        s1("u1 b7 hold",     4'b0000, 2'b00, 4'b0000, 4'b0000, 1, -1, 0);
        s1("u1 b8 hold",     4'b0000, 2'b00, 4'b0000, 4'b0000, 1, -1, 0);
        s1("u1 b9 firstpop", 4'b0000, 2'b00, 4'b0001, 4'b0000, 0, 0, 2);
        s1("u1 b10 next",    4'b0000, 2'b00, 4'b0010, 4'b0001, 0, 0, 3);
        // Async reset during RESUME
        s1("u1 c1 pause",    4'b0000, 2'b01, 4'b0000, 4'b0010, 0, -1, 0);
        s1("u1 c2 release",  4'b0000, 2'b00, 4'b0000, 4'b0000, 1, -1, 0);
        s1("u1 c3 resume",   4'b0000, 2'b00, 4'b0000, 4'b0000, 1, 0, 3);
        @(negedge clk);
        #2 rst1_n = 1'b0;
        #1;
        check("async rst pop", pop1, 4'b0000);
        check("async rst valid", val1, 4'b0000);
        check("async rst paused", pd1, 1'b0);
        check("async rst counts", cnt1, 64'd0);
        s1("u1 d1 postrst",  4'b0000, 2'b00, 4'b0001, 4'b0000, 0, 0, 0);
        s1("u1 d2 postrst",  4'b0000, 2'b00, 4'b0010, 4'b0001, 0, 0, 1);

        repeat (2) @(posedge clk);
        check("scoreboard drained", 64'(q0.size() + q1.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
